mem_access_ctrl: RTL and testbench

- Sequences every data-memory access from the MEM stage onto a valid/ready data-memory bus with variable latency.
- Splits misaligned halfword/word accesses into two aligned word transactions. Merges and extends load data, and generates store byte-enables and shifted write data.
- Stalls the pipeline until the access completes.
- Sits between the MEM-stage pipeline register and the data memory/peripheral bus.

---
 rtl/mem_access_ctrl_pkg.sv | 30 +++
 rtl/mem_access_ctrl_load_merge_extend.sv | 26 ++
 rtl/mem_access_ctrl.sv | 159 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// funct3 access-size codes, controller state encoding and the size-mask helper.
package mem_access_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_e;

  // Reserved funct3 encodings fall through to a full-word mask.
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return 4'b0001;
      F3_H, F3_HU: return 4'b0011;
      default:     return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_merge_extend.sv
// Combines up to two aligned read beats into one load result and applies
// funct3 sign/zero extension; shared with the cache refill path.
module load_merge_extend
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] Beat0Data,
  input  logic [31:0] Beat1Data,
  input  logic [1:0]  Offset,
  input  logic [2:0]  Funct3,
  output logic [31:0] Result
);

  logic [31:0] w_lo;

  always_comb begin
    w_lo = 32'({Beat1Data, Beat0Data} >> {Offset, 3'b000});
    case (Funct3)
      F3_B:    Result = {{24{w_lo[7]}}, w_lo[7:0]};
      F3_H:    Result = {{16{w_lo[15]}}, w_lo[15:0]};
      F3_BU:   Result = {24'd0, w_lo[7:0]};
      F3_HU:   Result = {16'd0, w_lo[15:0]};
      default: Result = w_lo;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences MEM-stage loads/stores onto a valid/ready data bus, splitting
// misaligned accesses into two aligned word beats and stalling until done.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned SPLIT_EN = 1,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              ReqValid,
  input  logic              ReqWrite,
  input  logic [2:0]        ReqFunct3,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [31:0]       ReqWData,
  output logic              StallM,
  output logic              RespValid,
  output logic [31:0]       RespData,
  output logic              MisalignErr,
  output logic              MemReqValid,
  input  logic              MemReqReady,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWrite,
  output logic [3:0]        MemByteEn,
  output logic [31:0]       MemWData,
  input  logic              MemRespValid,
  input  logic [31:0]       MemRData
);

  state_e              r_state;
  logic                r_write;
  logic [2:0]          r_funct3;
  logic [1:0]          r_off;
  logic                r_split;
  logic [3:0]          r_be_hi;
  logic [31:0]         r_wdata_hi;
  logic [31:0]         r_beat0;
  logic                r_resp_valid;
  logic [31:0]         r_resp_data;
  logic                r_misalign;
  logic                r_mem_req_valid;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_write;
  logic [3:0]          r_mem_be;
  logic [31:0]         r_mem_wdata;

  logic [7:0]          w_mask8;
  logic [63:0]         w_wdata64;
  logic                w_split;
  logic [31:0]         w_beat0;
  logic [31:0]         w_beat1;
  logic [31:0]         w_merged;

  always_comb begin
    w_mask8   = {4'b0000, size_mask(ReqFunct3)} << ReqAddr[1:0];
    w_split   = |w_mask8[7:4];
    w_wdata64 = {32'd0, ReqWData} << {ReqAddr[1:0], 3'b000};
    // The live bus word is merged in the same cycle it is captured so the
    // result can be registered on the transition into DONE.
    w_beat0   = (r_state == WAIT0) ? MemRData : r_beat0;
    w_beat1   = (r_state == WAIT1) ? MemRData : '0;
  end

  load_merge_extend u_merge (
    .Beat0Data (w_beat0),
    .Beat1Data (w_beat1),
    .Offset    (r_off),
    .Funct3    (r_funct3),
    .Result    (w_merged)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state         <= IDLE;
      r_write         <= 1'b0;
      r_funct3        <= '0;
      r_off           <= '0;
      r_split         <= 1'b0;
      r_be_hi         <= '0;
      r_wdata_hi      <= '0;
      r_beat0         <= '0;
      r_resp_valid    <= 1'b0;
      r_resp_data     <= '0;
      r_misalign      <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_write     <= 1'b0;
      r_mem_be        <= '0;
      r_mem_wdata     <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_misalign   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ReqValid) begin
            r_write    <= ReqWrite;
            r_funct3   <= ReqFunct3;
            r_off      <= ReqAddr[1:0];
            r_split    <= w_split;
            r_be_hi    <= ReqWrite ? w_mask8[7:4] : 4'b1111;
            r_wdata_hi <= ReqWrite ? w_wdata64[63:32] : '0;
            r_beat0    <= '0;
            if (SPLIT_EN == 0 && w_split) begin
              r_misalign <= 1'b1;
              r_state    <= ERR;
            end else begin
              r_mem_req_valid <= 1'b1;
              r_mem_addr      <= {ReqAddr[ADDR_W-1:2], 2'b00};
              r_mem_write     <= ReqWrite;
              r_mem_be        <= ReqWrite ? w_mask8[3:0] : 4'b1111;
              r_mem_wdata     <= ReqWrite ? w_wdata64[31:0] : '0;
              r_state         <= REQ0;
            end
          end
        end
        REQ0, REQ1: begin
          if (MemReqReady) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= (r_state == REQ0) ? WAIT0 : WAIT1;
          end
        end
        WAIT0, WAIT1: begin
          if (MemRespValid) begin
            r_beat0 <= w_beat0;
            if (r_state == WAIT0 && r_split) begin
              r_mem_req_valid <= 1'b1;
              r_mem_addr      <= r_mem_addr + ADDR_W'(4);
              r_mem_be        <= r_be_hi;
              r_mem_wdata     <= r_wdata_hi;
              r_state         <= REQ1;
            end else begin
              r_resp_valid <= 1'b1;
              r_resp_data  <= r_write ? '0 : w_merged;
              r_state      <= DONE;
            end
          end
        end
        DONE: begin
          r_resp_data <= '0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign StallM      = RESETn & (((r_state == IDLE) & ReqValid) |
                                 (r_state == REQ0) | (r_state == WAIT0) |
                                 (r_state == REQ1) | (r_state == WAIT1));
  assign RespValid   = r_resp_valid;
  assign RespData    = r_resp_data;
  assign MisalignErr = r_misalign;
  assign MemReqValid = r_mem_req_valid;
  assign MemAddr     = r_mem_addr;
  assign MemWrite    = r_mem_write;
  assign MemByteEn   = r_mem_be;
  assign MemWData    = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus random accesses against
// a byte-addressed memory model with randomized bus ready/response delays.
module tb_mem_access_ctrl;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        ReqValid, ReqWrite;
  logic [2:0]  ReqFunct3;
  logic [31:0] ReqAddr, ReqWData;
  logic        StallM, RespValid, MisalignErr;
  logic [31:0] RespData;
  logic        MemReqValid, MemReqReady, MemWrite, MemRespValid;
  logic [31:0] MemAddr, MemWData, MemRData;
  logic [3:0]  MemByteEn;

  logic        ns_ReqValid, ns_ReqWrite;
  logic [2:0]  ns_ReqFunct3;
  logic [31:0] ns_ReqAddr, ns_ReqWData;
  logic        ns_StallM, ns_RespValid, ns_MisalignErr;
  logic [31:0] ns_RespData;
  logic        ns_MemReqValid, ns_MemReqReady, ns_MemWrite, ns_MemRespValid;
  logic [31:0] ns_MemAddr, ns_MemWData, ns_MemRData;
  logic [3:0]  ns_MemByteEn;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_words [logic [31:0]];
  logic [31:0] last_addr [2];
  logic [3:0]  last_be   [2];
  logic [31:0] last_wd   [2];

  always #5 CLK = ~CLK;

  mem_access_ctrl #(.SPLIT_EN(1), .ADDR_W(32)) dut (
    .CLK(CLK), .RESETn(RESETn), .ReqValid(ReqValid), .ReqWrite(ReqWrite),
    .ReqFunct3(ReqFunct3), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .StallM(StallM), .RespValid(RespValid), .RespData(RespData),
    .MisalignErr(MisalignErr), .MemReqValid(MemReqValid), .MemReqReady(MemReqReady),
    .MemAddr(MemAddr), .MemWrite(MemWrite), .MemByteEn(MemByteEn),
    .MemWData(MemWData), .MemRespValid(MemRespValid), .MemRData(MemRData)
  );

  mem_access_ctrl #(.SPLIT_EN(0), .ADDR_W(32)) dut_ns (
    .CLK(CLK), .RESETn(RESETn), .ReqValid(ns_ReqValid), .ReqWrite(ns_ReqWrite),
    .ReqFunct3(ns_ReqFunct3), .ReqAddr(ns_ReqAddr), .ReqWData(ns_ReqWData),
    .StallM(ns_StallM), .RespValid(ns_RespValid), .RespData(ns_RespData),
    .MisalignErr(ns_MisalignErr), .MemReqValid(ns_MemReqValid), .MemReqReady(ns_MemReqReady),
    .MemAddr(ns_MemAddr), .MemWrite(ns_MemWrite), .MemByteEn(ns_MemByteEn),
    .MemWData(ns_MemWData), .MemRespValid(ns_MemRespValid), .MemRData(ns_MemRData)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] read_word(input logic [31:0] wa);
    if (mem_words.exists(wa)) return mem_words[wa];
    return (wa * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] ba);
    logic [31:0] w;
    w = read_word({ba[31:2], 2'b00});
    return w[ba[1:0]*8 +: 8];
  endfunction

  function automatic int acc_size(input logic [2:0] f3);
    case (f3)
      LB, LBU: return 1;
      LH, LHU: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < acc_size(f3); i++) v[i*8 +: 8] = mem_byte(a + 32'(i));
    if (f3 == LB && v[7])  v[31:8]  = '1;
    if (f3 == LH && v[15]) v[31:16] = '1;
    return v;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_stall"}, {31'd0, StallM}, 32'd0);
    check({tag, "_rvalid"}, {31'd0, RespValid}, 32'd0);
    check({tag, "_rdata"}, RespData, 32'd0);
    check({tag, "_merr"}, {31'd0, MisalignErr}, 32'd0);
    check({tag, "_mreqv"}, {31'd0, MemReqValid}, 32'd0);
    check({tag, "_maddr"}, MemAddr, 32'd0);
    check({tag, "_mwr"}, {31'd0, MemWrite}, 32'd0);
    check({tag, "_mbe"}, {28'd0, MemByteEn}, 32'd0);
    check({tag, "_mwd"}, MemWData, 32'd0);
  endtask

  // Starts just after a falling edge; plays the bus slave until the response.
  task automatic run_txn(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int rdy0, input int rdy1,
                         input int rsp, input bit junk, input bit abort_w1,
                         output int lat, output logic [31:0] rdata);
    logic [31:0] eaddr [2];
    logic [3:0]  ebe   [2];
    logic [31:0] edata [2];
    int nb, off, n, beat, rdy_cnt, rsp_cnt, bi, exp_lat;
    bit pending, seen, done;
    off = int'(a[1:0]);
    n   = acc_size(f3);
    nb  = (off + n > 4) ? 2 : 1;
    for (int b = 0; b < 2; b++) begin
      eaddr[b] = {a[31:2], 2'b00} + 32'(4 * b);
      ebe[b]   = wr ? 4'b0000 : 4'b1111;
      edata[b] = '0;
    end
    if (wr) for (int i = 0; i < n; i++) begin
      int k;
      k = off + i;
      ebe[k/4][k%4] = 1'b1;
      edata[k/4][(k%4)*8 +: 8] = wd[i*8 +: 8];
    end
    exp_lat = 1 + 2 * nb + rdy0 + rsp + ((nb == 2) ? rdy1 + rsp : 0);
    beat = 0; pending = 0; seen = 0; done = 0; rdy_cnt = rdy0; rsp_cnt = 0;
    lat = 0; rdata = '0;
    ReqValid = 1'b1; ReqWrite = wr; ReqFunct3 = f3; ReqAddr = a; ReqWData = wd;
    #1 check("stall_on_req", {31'd0, StallM}, 32'd1);
    while (!done && lat < 300) begin
      @(negedge CLK);
      lat++;
      MemRespValid = 1'b0;
      MemReqReady  = 1'b0;
      if (RespValid) begin
        done  = 1;
        rdata = RespData;
        check("stall_at_resp", {31'd0, StallM}, 32'd0);
        check("beats_issued", beat, nb);
        check("latency", lat, exp_lat);
        check("no_misalign", {31'd0, MisalignErr}, 32'd0);
      end else begin
        check("stall_busy", {31'd0, StallM}, 32'd1);
        if (MemReqValid) begin
          bi = (beat < 2) ? beat : 1;
          if (!seen) begin
            seen = 1;
            if (beat >= nb) check("extra_beat", beat, nb);
            last_addr[bi] = MemAddr; last_be[bi] = MemByteEn; last_wd[bi] = MemWData;
            check("beat_addr", MemAddr, eaddr[bi]);
            check("beat_write", {31'd0, MemWrite}, {31'd0, wr});
            check("beat_be", {28'd0, MemByteEn}, {28'd0, ebe[bi]});
            if (wr) check("beat_wdata", MemWData & lane_mask(ebe[bi]), edata[bi]);
          end else begin
            check("hold_addr", MemAddr, last_addr[bi]);
            check("hold_be", {28'd0, MemByteEn}, {28'd0, last_be[bi]});
            check("hold_wdata", MemWData, last_wd[bi]);
          end
          if (rdy_cnt == 0) begin
            MemReqReady = 1'b1;
            pending = 1; seen = 0; rsp_cnt = rsp;
            if (junk) begin MemRespValid = 1'b1; MemRData = 32'h5A5A_A5A5; end
          end else rdy_cnt--;
        end else if (pending) begin
          if (abort_w1 && beat == 1) return;
          if (rsp_cnt == 0) begin
            MemRespValid = 1'b1;
            MemRData = read_word(eaddr[(beat < 2) ? beat : 1]);
            beat++; pending = 0; rdy_cnt = rdy1;
          end else rsp_cnt--;
        end
      end
    end
    if (!done) check("resp_timeout", 32'd0, 32'd1);
    ReqValid = 1'b0;
    @(negedge CLK);
    check("resp_one_cycle", {31'd0, RespValid}, 32'd0);
    check("resp_data_clear", RespData, 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] rd, a, wd, expv;
    bit wr;
    logic [2:0] f3;

    RESETn = 1'b0;
    ReqValid = 0; ReqWrite = 0; ReqFunct3 = 0; ReqAddr = 0; ReqWData = 0;
    MemReqReady = 0; MemRespValid = 0; MemRData = 0;
    ns_ReqValid = 0; ns_ReqWrite = 0; ns_ReqFunct3 = 0; ns_ReqAddr = 0; ns_ReqWData = 0;
    ns_MemReqReady = 1; ns_MemRespValid = 0; ns_MemRData = 0;
    #2 check_outputs_zero("reset");
    @(negedge CLK); @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);

    // 1: aligned word load
    mem_words[32'h1000] = 32'hDEAD_BEEF;
    run_txn(0, LW, 32'h1000, 0, 0, 0, 0, 0, 0, lat, rd);
    check("t1_data", rd, 32'hDEAD_BEEF);
    check("t1_lat", lat, 3);
    check("t1_addr", last_addr[0], 32'h1000);
    check("t1_be", {28'd0, last_be[0]}, 32'hF);

    // 2: byte loads, signed and unsigned
    mem_words[32'h1000] = 32'h80FF_FFFF;
    run_txn(0, LB, 32'h1003, 0, 0, 0, 0, 0, 0, lat, rd);
    check("t2_lb", rd, 32'hFFFF_FF80);
    run_txn(0, LBU, 32'h1003, 0, 0, 0, 1, 1, 0, lat, rd);
    check("t2_lbu", rd, 32'h0000_0080);

    // 3: split halfword store
    run_txn(1, LH, 32'h2003, 32'h0000_ABCD, 0, 0, 0, 0, 0, lat, rd);
    check("t3_rdata", rd, 32'd0);
    check("t3_lat", lat, 5);
    check("t3_a0", last_addr[0], 32'h2000);
    check("t3_be0", {28'd0, last_be[0]}, 32'h8);
    check("t3_d0", {24'd0, last_wd[0][31:24]}, 32'hCD);
    check("t3_a1", last_addr[1], 32'h2004);
    check("t3_be1", {28'd0, last_be[1]}, 32'h1);
    check("t3_d1", {24'd0, last_wd[1][7:0]}, 32'hAB);

    // 4: split word load, then with ready held low for 4 cycles
    mem_words[32'h3000] = 32'h4433_2211;
    mem_words[32'h3004] = 32'h8877_6655;
    run_txn(0, LW, 32'h3002, 0, 0, 0, 0, 0, 0, lat, rd);
    check("t4_data", rd, 32'h6655_4433);
    check("t4_lat", lat, 5);
    run_txn(0, LW, 32'h3002, 0, 4, 0, 0, 0, 0, lat, rd);
    check("t4_data_slow", rd, 32'h6655_4433);
    check("t4_lat_slow", lat, 9);

    // 5: no-split instance rejects misaligned, accepts aligned
    ns_ReqValid = 1; ns_ReqWrite = 0; ns_ReqFunct3 = LH; ns_ReqAddr = 32'h3;
    #1 check("t5_stall_req", {31'd0, ns_StallM}, 32'd1);
    @(negedge CLK);
    check("t5_merr", {31'd0, ns_MisalignErr}, 32'd1);
    check("t5_no_bus", {31'd0, ns_MemReqValid}, 32'd0);
    check("t5_no_stall", {31'd0, ns_StallM}, 32'd0);
    ns_ReqValid = 0;
    @(negedge CLK);
    check("t5_merr_pulse", {31'd0, ns_MisalignErr}, 32'd0);
    check("t5_no_bus2", {31'd0, ns_MemReqValid}, 32'd0);
    ns_ReqValid = 1; ns_ReqAddr = 32'h2;
    @(negedge CLK);
    check("t5_al_req", {31'd0, ns_MemReqValid}, 32'd1);
    check("t5_al_merr", {31'd0, ns_MisalignErr}, 32'd0);
    @(negedge CLK);
    ns_MemRespValid = 1; ns_MemRData = 32'h8001_0000;
    @(negedge CLK);
    ns_MemRespValid = 0; ns_ReqValid = 0;
    check("t5_al_rv", {31'd0, ns_RespValid}, 32'd1);
    check("t5_al_data", ns_RespData, 32'hFFFF_8001);

    // random accesses against the byte model
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
      wd = $urandom;
      expv = wr ? 32'd0 : model_load(f3, a);
      run_txn(wr, f3, a, wd, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0, lat, rd);
      check("rand_resp", rd, expv);
    end

    // 6: reset while waiting for the second beat
    run_txn(0, LW, 32'h3002, 0, 0, 0, 0, 0, 1, lat, rd);
    RESETn = 1'b0;
    #1 check_outputs_zero("t6_rst");
    ReqValid = 0;
    @(negedge CLK);
    RESETn = 1'b1;
    MemRespValid = 1'b1; MemRData = 32'h1234_5678;
    @(negedge CLK);
    MemRespValid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("t6_no_resp", {31'd0, RespValid}, 32'd0);
      check("t6_no_stall", {31'd0, StallM}, 32'd0);
      check("t6_no_req", {31'd0, MemReqValid}, 32'd0);
      @(negedge CLK);
    end
    run_txn(0, LW, 32'h1000, 0, 0, 0, 0, 0, 0, lat, rd);
    check("t6_after", rd, 32'h80FF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
